dogx_range_combiner: RTL and testbench

Parametrised dual-range combiner for the DOGX VCO-ADC back end. It takes the free-running wrapped counters of the pseudo-differential HSNR (gain 1) and HDR (reduced gain) oscillator pairs and differentiates them per sample. It selects or crossfades between ranges with an overload-hysteresis FSM and emits one saturated signed sample per conversion strobe. It generalises the fixed-width converter: counter, output, gain-ratio, fade-depth and timeout widths are all parametrised, and it adds a reversible multi-step crossfade and an explicit valid strobe.

---
 rtl/dogx_range_combiner.sv | 209 ++++++++++++++++++++
 tb/tb_dogx_range_combiner.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dogx_range_combiner.sv
// rtl/dogx_range_combiner.sv - dual-range VCO-ADC combiner with overload-hysteresis crossfade
// Stage A differentiates the wrapped counters; stage B steps the range FSM and blends the two ranges.
module dogx_range_combiner #(
  parameter int CNT_W      = 9,
  parameter int OUT_W      = 12,
  parameter int GAIN_SHIFT = 2,
  parameter int FADE_LOG2  = 2,
  parameter int TIMEOUT_W  = 5
) (
  input  logic                 CLK_24M,
  input  logic                 reset,
  input  logic                 sample_en,
  input  logic [CNT_W-1:0]     counter_HSNR_p,
  input  logic [CNT_W-1:0]     counter_HSNR_n,
  input  logic [CNT_W-1:0]     counter_HDR_p,
  input  logic [CNT_W-1:0]     counter_HDR_n,
  input  logic [CNT_W-1:0]     alpha_th_high,
  input  logic [CNT_W-1:0]     alpha_th_low,
  input  logic [TIMEOUT_W-1:0] alpha_timeout,
  input  logic                 use_progressive_alpha,
  output logic                 alpha_out,
  output logic [OUT_W-1:0]     converter_output,
  output logic                 out_valid
);

  localparam int W_W     = FADE_LOG2 + 1;
  localparam int D_W     = CNT_W + 1;
  localparam int ACC_RAW = CNT_W + GAIN_SHIFT + FADE_LOG2 + 4;
  localparam int ACC_W   = (ACC_RAW > OUT_W + 1) ? ACC_RAW : OUT_W + 1;

  localparam logic [W_W-1:0] W_FULL = W_W'(1 << FADE_LOG2);
  localparam logic signed [ACC_W-1:0] SAT_MAX = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SAT_MIN = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  typedef enum logic [1:0] {
    S_HSNR      = 2'd0,
    S_FADE_UP   = 2'd1,
    S_HDR       = 2'd2,
    S_FADE_DOWN = 2'd3
  } state_t;

  // Stage A: capture and differentiate
  logic [CNT_W-1:0]      prev_hsnr_p, prev_hsnr_n, prev_hdr_p, prev_hdr_n;
  logic                  primed, valid_a;
  logic signed [D_W-1:0] d_hsnr, d_hdr;
  logic [CNT_W-1:0]      abs_hdr;

  logic [CNT_W-1:0]      diff_hsnr_p, diff_hsnr_n, diff_hdr_p, diff_hdr_n;
  logic signed [D_W-1:0] d_hsnr_next, d_hdr_next, neg_hdr_next;
  logic [CNT_W-1:0]      abs_hdr_next;

  always_comb begin
    diff_hsnr_p  = counter_HSNR_p - prev_hsnr_p;
    diff_hsnr_n  = counter_HSNR_n - prev_hsnr_n;
    diff_hdr_p   = counter_HDR_p  - prev_hdr_p;
    diff_hdr_n   = counter_HDR_n  - prev_hdr_n;
    d_hsnr_next  = $signed({1'b0, diff_hsnr_p}) - $signed({1'b0, diff_hsnr_n});
    d_hdr_next   = $signed({1'b0, diff_hdr_p})  - $signed({1'b0, diff_hdr_n});
    neg_hdr_next = -d_hdr_next;
    abs_hdr_next = d_hdr_next[D_W-1] ? neg_hdr_next[CNT_W-1:0] : d_hdr_next[CNT_W-1:0];
  end

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      prev_hsnr_p <= '0;
      prev_hsnr_n <= '0;
      prev_hdr_p  <= '0;
      prev_hdr_n  <= '0;
      primed      <= 1'b0;
      valid_a     <= 1'b0;
      d_hsnr      <= '0;
      d_hdr       <= '0;
      abs_hdr     <= '0;
    end else begin
      valid_a <= 1'b0;
      if (sample_en) begin
        prev_hsnr_p <= counter_HSNR_p;
        prev_hsnr_n <= counter_HSNR_n;
        prev_hdr_p  <= counter_HDR_p;
        prev_hdr_n  <= counter_HDR_n;
        primed      <= 1'b1;
        // The very first capture has no valid history to difference against.
        if (primed) begin
          d_hsnr  <= d_hsnr_next;
          d_hdr   <= d_hdr_next;
          abs_hdr <= abs_hdr_next;
          valid_a <= 1'b1;
        end
      end
    end
  end

  // Stage B: range FSM and crossfade weight
  state_t               state, state_next;
  logic [W_W-1:0]       w, w_next, w_up, w_dn;
  logic [TIMEOUT_W-1:0] quiet, quiet_next, tmo_eff;
  logic [TIMEOUT_W:0]   quiet_inc;
  logic                 hi, lo, prog;

  always_comb begin
    hi        = (abs_hdr >= alpha_th_high);
    lo        = (abs_hdr <  alpha_th_low);
    prog      = use_progressive_alpha && (FADE_LOG2 != 0);
    tmo_eff   = (alpha_timeout == '0) ? TIMEOUT_W'(1) : alpha_timeout;
    quiet_inc = {1'b0, quiet} + (TIMEOUT_W+1)'(1);
    w_up      = w + W_W'(1);
    w_dn      = w - W_W'(1);

    state_next = state;
    w_next     = w;
    quiet_next = '0;
    case (state)
      S_HSNR: begin
        if (hi) begin
          if (prog) begin
            state_next = S_FADE_UP;
            w_next     = W_W'(1);
          end else begin
            state_next = S_HDR;
            w_next     = W_FULL;
          end
        end
      end
      S_FADE_UP: begin
        if (!prog || w_up == W_FULL) begin
          state_next = S_HDR;
          w_next     = W_FULL;
        end else begin
          w_next = w_up;
        end
      end
      S_HDR: begin
        // Overload wins: any hi sample clears the quiet run.
        if (!hi && lo) begin
          if (quiet_inc >= {1'b0, tmo_eff}) begin
            if (prog) begin
              state_next = S_FADE_DOWN;
              w_next     = W_FULL - W_W'(1);
            end else begin
              state_next = S_HSNR;
              w_next     = '0;
            end
          end else begin
            quiet_next = quiet_inc[TIMEOUT_W-1:0];
          end
        end
      end
      S_FADE_DOWN: begin
        if (!prog) begin
          state_next = S_HSNR;
          w_next     = '0;
        end else if (hi) begin
          state_next = (w_up == W_FULL) ? S_HDR : S_FADE_UP;
          w_next     = w_up;
        end else if (w_dn == '0) begin
          state_next = S_HSNR;
          w_next     = '0;
        end else begin
          w_next = w_dn;
        end
      end
      default: begin
        state_next = S_HSNR;
        w_next     = '0;
      end
    endcase
  end

  // Blend with the weight chosen for this very sample, floor-shift, then saturate.
  logic signed [ACC_W-1:0] hs_ext, hd_ext, wa, wb, acc, y_full;
  logic [OUT_W-1:0]        y_sat;

  always_comb begin
    hs_ext = ACC_W'(d_hsnr);
    hd_ext = ACC_W'(d_hdr) <<< GAIN_SHIFT;
    wb     = ACC_W'(w_next);
    wa     = ACC_W'(W_FULL) - wb;
    acc    = hs_ext * wa + hd_ext * wb;
    y_full = acc >>> FADE_LOG2;
    if (y_full > SAT_MAX) begin
      y_sat = SAT_MAX[OUT_W-1:0];
    end else if (y_full < SAT_MIN) begin
      y_sat = SAT_MIN[OUT_W-1:0];
    end else begin
      y_sat = y_full[OUT_W-1:0];
    end
  end

  always_ff @(posedge CLK_24M or negedge reset) begin
    if (!reset) begin
      state            <= S_HSNR;
      w                <= '0;
      quiet            <= '0;
      converter_output <= '0;
      out_valid        <= 1'b0;
      alpha_out        <= 1'b0;
    end else begin
      out_valid <= valid_a;
      if (valid_a) begin
        state            <= state_next;
        w                <= w_next;
        quiet            <= quiet_next;
        converter_output <= y_sat;
        alpha_out        <= (w_next != '0);
      end
    end
  end

endmodule

// File: tb/tb_dogx_range_combiner.sv
// tb/tb_dogx_range_combiner.sv - directed self-checking bench for dogx_range_combiner
module tb_dogx_range_combiner;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        sample_en = 1'b0;
  logic        prog = 1'b0;
  logic [8:0]  hp = '0, hn = '0, dp = '0, dn = '0;
  logic [8:0]  th_high = 9'd10, th_low = 9'd7;
  logic [4:0]  tmo = 5'd4;
  logic        alpha_out, out_valid;
  logic [10:0] conv;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  dogx_range_combiner #(
    .CNT_W(9), .OUT_W(11), .GAIN_SHIFT(2), .FADE_LOG2(2), .TIMEOUT_W(5)
  ) dut (
    .CLK_24M(clk),
    .reset(rst_n),
    .sample_en(sample_en),
    .counter_HSNR_p(hp),
    .counter_HSNR_n(hn),
    .counter_HDR_p(dp),
    .counter_HDR_n(dn),
    .alpha_th_high(th_high),
    .alpha_th_low(th_low),
    .alpha_timeout(tmo),
    .use_progressive_alpha(prog),
    .alpha_out(alpha_out),
    .converter_output(conv),
    .out_valid(out_valid)
  );

  task automatic do_reset();
    rst_n = 1'b0;
    sample_en = 1'b0;
    hp = '0; hn = '0; dp = '0; dn = '0;
    th_high = 9'd10; th_low = 9'd7; tmo = 5'd4; prog = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic strobe4(input int a, input int b, input int c, input int d);
    hp = hp + 9'(a);
    hn = hn + 9'(b);
    dp = dp + 9'(c);
    dn = dn + 9'(d);
    sample_en = 1'b1;
    @(posedge clk);
    #1 sample_en = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic strobe2(input int dh, input int dd);
    strobe4(dh >= 0 ? dh : 0, dh < 0 ? -dh : 0, dd >= 0 ? dd : 0, dd < 0 ? -dd : 0);
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_cmp++;
    if (conv !== 11'd0 || out_valid !== 1'b0 || alpha_out !== 1'b0) begin
      n_bad++;
      $display("FAIL reset: out=%0d valid=%0b alpha=%0b, want 0/0/0", $signed(conv), out_valid, alpha_out);
    end
  endtask

  task automatic test_steady();
    do_reset();
    strobe4(10, 6, 3, 2);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL steady_prime: valid=%0b, want 0", out_valid);
    end
    repeat (6) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      strobe4(10, 6, 3, 2);
      n_cmp++;
      if (conv !== 11'd4 || out_valid !== 1'b1 || alpha_out !== 1'b0) begin
        n_bad++;
        $display("FAIL steady[%0d]: out=%0d valid=%0b alpha=%0b, want 4/1/0", k, $signed(conv), out_valid, alpha_out);
      end
      @(posedge clk);
      #1;
      n_cmp++;
      if (out_valid !== 1'b0) begin
        n_bad++;
        $display("FAIL steady_pulse[%0d]: valid=%0b, want 0", k, out_valid);
      end
      repeat (5) @(posedge clk);
      #1;
    end
  endtask

  task automatic test_wrap();
    do_reset();
    hp = 9'd498;
    strobe4(0, 0, 0, 0);
    for (int k = 0; k < 2; k++) begin
      strobe4(10, 6, 0, 0);
      n_cmp++;
      if (conv !== 11'd4 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL wrap[%0d]: out=%0d valid=%0b, want 4/1 (hp=%0d)", k, $signed(conv), out_valid, hp);
      end
    end
  endtask

  task automatic test_hard_switch();
    int dd[8] = '{12, 3, 3, 8, 3, 3, 3, 3};
    int eo[8] = '{48, 12, 12, 32, 12, 12, 12, 40};
    int ea[8] = '{1, 1, 1, 1, 1, 1, 1, 0};
    do_reset();
    strobe2(0, 0);
    for (int i = 0; i < 8; i++) begin
      strobe2(40, dd[i]);
      n_cmp++;
      if (conv !== 11'(eo[i]) || out_valid !== 1'b1 || alpha_out !== 1'(ea[i])) begin
        n_bad++;
        $display("FAIL hard_switch[%0d]: out=%0d valid=%0b alpha=%0b, want out=%0d valid=1 alpha=%0d",
                 i, $signed(conv), out_valid, alpha_out, eo[i], ea[i]);
      end
    end
  endtask

  task automatic test_progressive();
    int thh[12] = '{10, 10, 10, 10, 20, 20, 10, 10, 20, 20, 20, 20};
    int thl[12] = '{7, 7, 7, 7, 13, 13, 7, 7, 13, 13, 13, 13};
    int eo[12]  = '{42, 44, 46, 48, 46, 44, 46, 48, 46, 44, 42, 40};
    do_reset();
    prog = 1'b1;
    tmo = 5'd1;
    strobe2(0, 0);
    for (int i = 0; i < 12; i++) begin
      th_high = 9'(thh[i]);
      th_low  = 9'(thl[i]);
      strobe2(40, 12);
      n_cmp++;
      if (conv !== 11'(eo[i]) || out_valid !== 1'b1 || alpha_out !== (i != 11)) begin
        n_bad++;
        $display("FAIL progressive[%0d]: out=%0d valid=%0b alpha=%0b, want out=%0d valid=1 alpha=%0b",
                 i, $signed(conv), out_valid, alpha_out, eo[i], (i != 11));
      end
    end
  endtask

  task automatic test_floor();
    int eo[2] = '{-11, -21};
    do_reset();
    prog = 1'b1;
    strobe2(0, 0);
    for (int i = 0; i < 2; i++) begin
      strobe2(-1, -10);
      n_cmp++;
      if (conv !== 11'(eo[i]) || alpha_out !== 1'b1) begin
        n_bad++;
        $display("FAIL floor[%0d]: out=%0d alpha=%0b, want out=%0d alpha=1", i, $signed(conv), alpha_out, eo[i]);
      end
    end
  endtask

  task automatic test_saturation();
    int dd[2] = '{511, -511};
    int eo[2] = '{1023, -1024};
    do_reset();
    strobe2(0, 0);
    for (int i = 0; i < 2; i++) begin
      strobe2(0, dd[i]);
      n_cmp++;
      if (conv !== 11'(eo[i]) || alpha_out !== 1'b1) begin
        n_bad++;
        $display("FAIL saturation[%0d]: out=%0d alpha=%0b, want out=%0d alpha=1", i, $signed(conv), alpha_out, eo[i]);
      end
    end
  endtask

  task automatic test_timeout_zero();
    do_reset();
    tmo = 5'd0;
    strobe2(0, 0);
    strobe2(40, 12);
    n_cmp++;
    if (conv !== 11'd48 || alpha_out !== 1'b1) begin
      n_bad++;
      $display("FAIL timeout0_enter: out=%0d alpha=%0b, want 48/1", $signed(conv), alpha_out);
    end
    strobe2(40, 3);
    n_cmp++;
    if (conv !== 11'd40 || alpha_out !== 1'b0) begin
      n_bad++;
      $display("FAIL timeout0_leave: out=%0d alpha=%0b, want 40/0", $signed(conv), alpha_out);
    end
  endtask

  task automatic test_snap();
    do_reset();
    prog = 1'b1;
    tmo = 5'd1;
    strobe2(0, 0);
    strobe2(40, 12);
    n_cmp++;
    if (conv !== 11'd42) begin
      n_bad++;
      $display("FAIL snap_fade_up: out=%0d, want 42", $signed(conv));
    end
    prog = 1'b0;
    strobe2(40, 12);
    n_cmp++;
    if (conv !== 11'd48 || alpha_out !== 1'b1) begin
      n_bad++;
      $display("FAIL snap_to_hdr: out=%0d alpha=%0b, want 48/1", $signed(conv), alpha_out);
    end
    prog = 1'b1;
    th_high = 9'd20;
    th_low = 9'd13;
    strobe2(40, 12);
    n_cmp++;
    if (conv !== 11'd46) begin
      n_bad++;
      $display("FAIL snap_fade_down: out=%0d, want 46", $signed(conv));
    end
    prog = 1'b0;
    strobe2(40, 12);
    n_cmp++;
    if (conv !== 11'd40 || alpha_out !== 1'b0) begin
      n_bad++;
      $display("FAIL snap_to_hsnr: out=%0d alpha=%0b, want 40/0", $signed(conv), alpha_out);
    end
  endtask

  task automatic test_reset_mid_fade();
    do_reset();
    prog = 1'b1;
    strobe2(0, 0);
    strobe2(40, 12);
    n_cmp++;
    if (conv !== 11'd42 || out_valid !== 1'b1 || alpha_out !== 1'b1) begin
      n_bad++;
      $display("FAIL midfade_pre: out=%0d valid=%0b alpha=%0b, want 42/1/1", $signed(conv), out_valid, alpha_out);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (conv !== 11'd0 || out_valid !== 1'b0 || alpha_out !== 1'b0) begin
      n_bad++;
      $display("FAIL midfade_async: out=%0d valid=%0b alpha=%0b, want 0/0/0", $signed(conv), out_valid, alpha_out);
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    strobe2(40, 12);
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL midfade_reprime: valid=%0b, want 0", out_valid);
    end
    strobe2(40, 3);
    n_cmp++;
    if (conv !== 11'd40 || out_valid !== 1'b1 || alpha_out !== 1'b0) begin
      n_bad++;
      $display("FAIL midfade_restart: out=%0d valid=%0b alpha=%0b, want 40/1/0", $signed(conv), out_valid, alpha_out);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    sample_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      hp = hp + 9'd10;
      hn = hn + 9'd6;
      dp = dp + 9'd3;
      dn = dn + 9'd2;
      @(posedge clk);
      #1;
      n_cmp++;
      if (i < 2) begin
        if (out_valid !== 1'b0) begin
          n_bad++;
          $display("FAIL b2b_lead[%0d]: valid=%0b, want 0", i, out_valid);
        end
      end else if (conv !== 11'd4 || out_valid !== 1'b1) begin
        n_bad++;
        $display("FAIL b2b[%0d]: out=%0d valid=%0b, want 4/1", i, $signed(conv), out_valid);
      end
    end
    sample_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_steady();
    test_wrap();
    test_hard_switch();
    test_progressive();
    test_floor();
    test_saturation();
    test_timeout_zero();
    test_snap();
    test_reset_mid_fade();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
